data_axi_bridge: RTL and testbench

Data-side bridge between the CPU's SRAM-like data bus and a single AXI4 master port. It sits directly downstream of the data-request state machine: it consumes `req`, `wr`, `size`, `wstrb`, `addr` and `wdata`, and it returns `addr_ok`, `data_ok` and `rdata` to the pipeline. It runs one outstanding transaction at a time, which matches the upstream rule of one request in flight until `data_ok`.

---
 rtl/data_axi_bridge_pkg.sv | 30 +++
 rtl/data_axi_bridge_if.sv | 75 +++++++
 rtl/data_axi_bridge.sv | 108 ++++++++++
 tb/tb_data_axi_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_axi_bridge_pkg.sv
// Shared definitions for the data-side SRAM-like to AXI4 bridge.
// Holds the FSM state encoding, the fixed AXI attribute values and the
// request-latch record.
package data_axi_bridge_pkg;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      StIdle  = 3'd0,
      StRdAr  = 3'd1,
      StRdR   = 3'd2,
      StWrAwW = 3'd3,
      StWrB   = 3'd4,
      StDone  = 3'd5
   } state_e;

   localparam logic [1:0] AxiBurstIncr = 2'b01;
   localparam logic [7:0] AxiLenSingle = 8'd0;
   localparam logic [3:0] DefaultId    = 4'd1;

   // Fields frozen from accept until completion. Direction is not stored here:
   // the FSM state already encodes it.
   typedef struct packed {
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/data_axi_bridge_if.sv
// Bus bundle for data_axi_bridge: the CPU-side SRAM-like request/response
// signals and the single-beat AXI4 master channels (AR, R, AW, W, B).
// master: the bridge view (drives AXI requests and SRAM-like responses).
// slave:  the environment view (drives CPU requests and AXI responses).
// rresp/rid/bresp are not carried because the bridge ignores them.
interface data_axi_bridge_if;
   // SRAM-like side
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   // AR / R
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata_axi;
   logic        rvalid;
   logic        rready;
   // AW / W / B
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata_axi;
   logic [3:0]  wstrb_axi;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready, rdata_axi, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wdata_axi, wstrb_axi, wlast, wvalid,
      input  wready, bvalid,
      output bready
   );

   modport slave (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready, rdata_axi, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wdata_axi, wstrb_axi, wlast, wvalid,
      output wready, bvalid,
      input  bready
   );
endinterface

// File: rtl/data_axi_bridge.sv
// Data-side bridge from the CPU SRAM-like bus to one AXI4 master port.
// One transaction in flight: accept in IDLE, run AR/R or AW+W/B, pulse
// data_ok in DONE, then return to IDLE.
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   bus    - data_axi_bridge_if.master (SRAM-like side + AXI channels)
module data_axi_bridge
   import data_axi_bridge_pkg::*;
#(
   parameter logic [3:0] ID = DefaultId
) (
   input logic                clk,
   input logic                resetn,
   data_axi_bridge_if.master  bus
);

   state_e      state_q, state_d;
   req_t        req_q, req_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               req_d     = '{size: bus.size, wstrb: bus.wstrb, addr: bus.addr,
                             wdata: bus.wdata};
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = bus.wr ? StWrAwW : StRdAr;
            end
         end
         StRdAr: if (bus.arready) state_d = StRdR;
         StRdR: begin
            if (bus.rvalid) begin
               rdata_d = bus.rdata_axi;
               state_d = StDone;
            end
         end
         StWrAwW: begin
            // A valid is only high while its flag is clear, so ready alone marks the handshake.
            aw_done_d = aw_done_q | bus.awready;
            w_done_d  = w_done_q | bus.wready;
            if (aw_done_d && w_done_d) state_d = StWrB;
         end
         StWrB: if (bus.bvalid) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         req_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
      end
   end

   // Every handshake output decodes from registered state, so an async reset
   // drops them immediately and nothing depends combinationally on inputs.
   assign bus.addr_ok = (state_q == StIdle);
   assign bus.data_ok = (state_q == StDone);
   assign bus.rdata   = rdata_q;

   assign bus.arvalid = (state_q == StRdAr);
   assign bus.rready  = (state_q == StRdR);
   assign bus.awvalid = (state_q == StWrAwW) && !aw_done_q;
   assign bus.wvalid  = (state_q == StWrAwW) && !w_done_q;
   assign bus.bready  = (state_q == StWrB);

   assign bus.araddr    = req_q.addr;
   assign bus.arsize    = {1'b0, req_q.size};
   assign bus.awaddr    = req_q.addr;
   assign bus.awsize    = {1'b0, req_q.size};
   assign bus.wdata_axi = req_q.wdata;
   assign bus.wstrb_axi = req_q.wstrb;
   assign bus.wlast     = 1'b1;

   assign bus.arid    = ID;
   assign bus.arlen   = AxiLenSingle;
   assign bus.arburst = AxiBurstIncr;
   assign bus.arlock  = 1'b0;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.awid    = ID;
   assign bus.awlen   = AxiLenSingle;
   assign bus.awburst = AxiBurstIncr;
   assign bus.awlock  = 1'b0;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: directed vector table, a hand-written
// async-reset sequence, and randomized transactions against a latency/data model.
module tb_data_axi_bridge;
   import data_axi_bridge_pkg::*;

   localparam logic [3:0] TbId = 4'd5;
   localparam int MaxCycles = 60;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;      // data returned on R
      int          ar_w;    // cycles arready held low while arvalid
      int          r_w;     // cycles rvalid held low while rready
      int          aw_w;
      int          w_w;
      int          b_w;
      bit          hold;    // keep req high (with scrambled fields) while busy
      int          exp_lat; // accept-to-data_ok cycles
   } txn_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   data_axi_bridge_if bus ();

   data_axi_bridge #(.ID(TbId)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] model_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept-to-data_ok latency from the protocol rules: one cycle per phase
   // plus one per stalled cycle; AW and W overlap so only the slower counts.
   function automatic int model_lat(input txn_t t);
      if (t.wr) return 3 + ((t.aw_w > t.w_w) ? t.aw_w : t.w_w) + t.b_w;
      return 3 + t.ar_w + t.r_w;
   endfunction

   task automatic run_txn(input txn_t t);
      int ar_c = t.ar_w, r_c = t.r_w, aw_c = t.aw_w, w_c = t.w_w, b_c = t.b_w;
      int cyc = 0;
      int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
      bit ar_pend = 0, aw_pend = 0, w_pend = 0, done = 0;
      logic [31:0] exp_rdata;
      exp_rdata = t.wr ? model_rdata : t.rd;

      check("addr_ok before accept", 32'(bus.addr_ok), 32'd1);
      bus.req = 1'b1; bus.wr = t.wr; bus.size = t.size; bus.wstrb = t.wstrb;
      bus.addr = t.addr; bus.wdata = t.wdata;
      step();
      // Upstream changes after accept must have no effect.
      bus.req = t.hold; bus.wr = ~t.wr; bus.size = ~t.size; bus.wstrb = ~t.wstrb;
      bus.addr = ~t.addr; bus.wdata = ~t.wdata;

      while (!done && cyc < MaxCycles) begin
         cyc++;
         check("addr_ok busy", 32'(bus.addr_ok), 32'd0);
         if (ar_pend) check("arvalid held", 32'(bus.arvalid), 32'd1);
         if (aw_pend) check("awvalid held", 32'(bus.awvalid), 32'd1);
         if (w_pend)  check("wvalid held", 32'(bus.wvalid), 32'd1);
         if (t.wr) check("read channel idle on write", 32'(bus.arvalid | bus.rready), 32'd0);
         else check("write channel idle on read",
                    32'(bus.awvalid | bus.wvalid | bus.bready), 32'd0);
         if (bus.arvalid) begin
            check("araddr", bus.araddr, t.addr);
            check("arsize", 32'(bus.arsize), 32'({1'b0, t.size}));
            check("arvalid after handshake", 32'(ar_hs), 32'd0);
         end
         if (bus.awvalid) begin
            check("awaddr", bus.awaddr, t.addr);
            check("awsize", 32'(bus.awsize), 32'({1'b0, t.size}));
            check("awvalid after handshake", 32'(aw_hs), 32'd0);
         end
         if (bus.wvalid) begin
            check("wdata_axi", bus.wdata_axi, t.wdata);
            check("wstrb_axi", 32'(bus.wstrb_axi), 32'(t.wstrb));
            check("wvalid after handshake", 32'(w_hs), 32'd0);
         end

         bus.arready = 1'b0;
         if (bus.arvalid) begin if (ar_c > 0) ar_c--; else bus.arready = 1'b1; end
         bus.awready = 1'b0;
         if (bus.awvalid) begin if (aw_c > 0) aw_c--; else bus.awready = 1'b1; end
         bus.wready = 1'b0;
         if (bus.wvalid) begin if (w_c > 0) w_c--; else bus.wready = 1'b1; end
         bus.rvalid = 1'b0;
         bus.rdata_axi = $urandom;
         if (bus.rready) begin
            if (r_c > 0) r_c--;
            else begin bus.rvalid = 1'b1; bus.rdata_axi = t.rd; end
         end
         bus.bvalid = 1'b0;
         if (bus.bready) begin if (b_c > 0) b_c--; else bus.bvalid = 1'b1; end

         ar_pend = bus.arvalid & ~bus.arready;
         aw_pend = bus.awvalid & ~bus.awready;
         w_pend  = bus.wvalid & ~bus.wready;
         ar_hs += int'(bus.arvalid & bus.arready);
         aw_hs += int'(bus.awvalid & bus.awready);
         w_hs  += int'(bus.wvalid & bus.wready);
         r_hs  += int'(bus.rvalid & bus.rready);
         b_hs  += int'(bus.bvalid & bus.bready);

         if (bus.data_ok) begin
            done = 1;
            bus.req = 1'b0;
            check("latency", 32'(cyc), 32'(t.exp_lat));
            check("rdata at data_ok", bus.rdata, exp_rdata);
            if (t.wr) check("aw/w/b handshakes", 32'(aw_hs + w_hs + b_hs), 32'd3);
            else check("ar/r handshakes", 32'(ar_hs + r_hs), 32'd2);
         end
         step();
      end
      if (!done) begin
         check("data_ok timeout", 32'(cyc), 32'(t.exp_lat));
         bus.req = 1'b0;
      end
      check("data_ok single pulse", 32'(bus.data_ok), 32'd0);
      check("rdata holds", bus.rdata, exp_rdata);
      model_rdata = exp_rdata;
   endtask

   txn_t vec[6];
   txn_t rt;

   initial begin
      //           wr    size  wstrb    addr           wdata          rd             ar r aw w b hold lat
      vec[0] = '{1'b0, 2'd2, 4'hF,   32'h1C00_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 3};
      vec[1] = '{1'b0, 2'd2, 4'hF,   32'h1C00_0100, 32'h0,         32'h1234_5678, 4, 2, 0, 0, 0, 1, 9};
      vec[2] = '{1'b1, 2'd1, 4'h3,   32'h1C00_0202, 32'h0000_A5A5, 32'h0,         0, 0, 2, 0, 1, 0, 6};
      vec[3] = '{1'b1, 2'd2, 4'hF,   32'h1C00_0300, 32'hCAFE_F00D, 32'h0,         0, 0, 0, 0, 0, 1, 3};
      vec[4] = '{1'b1, 2'd0, 4'h4,   32'h1C00_0402, 32'h0077_0000, 32'h0,         0, 0, 0, 3, 0, 0, 6};
      vec[5] = '{1'b0, 2'd0, 4'h1,   32'h1C00_0501, 32'h0,         32'h0000_0042, 1, 0, 0, 0, 0, 1, 4};

      bus.req = 1'b0; bus.wr = 1'b0; bus.size = '0; bus.wstrb = '0; bus.addr = '0;
      bus.wdata = '0; bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata_axi = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
      #1;
      check("reset addr_ok", 32'(bus.addr_ok), 32'd1);
      check("reset data_ok", 32'(bus.data_ok), 32'd0);
      check("reset valids/readies",
            32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
      check("reset rdata", bus.rdata, 32'd0);
      check("reset araddr", bus.araddr, 32'd0);
      check("reset awaddr", bus.awaddr, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      step();

      check("arid", 32'(bus.arid), 32'(TbId));
      check("awid", 32'(bus.awid), 32'(TbId));
      check("len/burst/wlast",
            32'({bus.arlen, bus.awlen, bus.arburst, bus.awburst, bus.wlast}),
            32'({8'd0, 8'd0, 2'b01, 2'b01, 1'b1}));
      check("lock/cache/prot",
            32'({bus.arlock, bus.arcache, bus.arprot, bus.awlock, bus.awcache, bus.awprot}),
            32'd0);

      for (int i = 0; i < 6; i++) run_txn(vec[i]);

      // Async reset while arvalid is high.
      bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h1C00_0600;
      step();
      bus.req = 1'b0; bus.arready = 1'b0;
      check("arvalid before reset", 32'(bus.arvalid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("arvalid drops on reset", 32'(bus.arvalid), 32'd0);
      check("addr_ok on reset", 32'(bus.addr_ok), 32'd1);
      check("rready on reset", 32'(bus.rready), 32'd0);
      check("araddr on reset", bus.araddr, 32'd0);
      check("rdata on reset", bus.rdata, 32'd0);
      model_rdata = '0;
      @(negedge clk) resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no data_ok after reset", 32'(bus.data_ok), 32'd0);
      end
      rt = '{1'b0, 2'd2, 4'hF, 32'h1C00_0700, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 0, 0, 0, 5};
      run_txn(rt);

      for (int i = 0; i < 40; i++) begin
         rt.wr    = 1'($urandom_range(0, 1));
         rt.size  = 2'($urandom_range(0, 2));
         rt.wstrb = 4'($urandom);
         rt.addr  = $urandom;
         rt.wdata = $urandom;
         rt.rd    = $urandom;
         rt.ar_w  = $urandom_range(0, 3);
         rt.r_w   = $urandom_range(0, 3);
         rt.aw_w  = $urandom_range(0, 3);
         rt.w_w   = $urandom_range(0, 3);
         rt.b_w   = $urandom_range(0, 3);
         rt.hold  = 1'($urandom_range(0, 1));
         rt.exp_lat = model_lat(rt);
         run_txn(rt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
